// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Parity generation is built only when the UART_TX_CFG_PARITY_EN macro is defined.
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW       = $clog2(DATA_BITS);
`ifdef UART_TX_CFG_PARITY_EN
  localparam bit PAR_ACT  = (PARITY != 0);
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_n, tx_busy_n, tx_done_n;
  logic                 bit_end;
`ifdef UART_TX_CFG_PARITY_EN
  logic                 par_bit, par_bit_n;
`endif

  assign tx_ready = (state == ST_IDLE) && reset_n;
  assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      tx_busy  <= tx_busy_n;
      tx_done  <= tx_done_n;
`ifdef UART_TX_CFG_PARITY_EN
      par_bit  <= par_bit_n;
`endif
    end
  end

  // Line value is computed one cycle ahead so tx leaves a flop on each bit edge.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    tx_busy_n  = tx_busy;
    tx_done_n  = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
    par_bit_n  = par_bit;
`endif
    if (state != ST_IDLE) begin
      baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_n    = ST_START;
          shreg_n    = tx_data;
          tx_n       = 1'b0;
          tx_busy_n  = 1'b1;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
          par_bit_n  = (^tx_data) ^ (PARITY == 2);
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_CFG_PARITY_EN
            if (PAR_ACT) begin
              state_n = ST_PARITY;
              tx_n    = par_bit;
            end else
`endif
            begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_n   = ST_IDLE;
            tx_busy_n = 1'b0;
            tx_done_n = 1'b1;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at BAUD_DIV = 10 across four parameter sets.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i [4];
  logic [8:0] data_i = '0;
  logic       ready_o [4];
  logic       tx_o    [4];
  logic       busy_o  [4];
  logic       done_o  [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // 0: 8N1; 1: 7 data, 2 stop, odd; 2: 8 data, odd; 3: 8 data, even
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .tx_valid(valid_i[0]), .tx_data(data_i[7:0]),
    .tx_ready(ready_o[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .tx_valid(valid_i[1]), .tx_data(data_i[6:0]),
    .tx_ready(ready_o[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset_n(rst_n), .tx_valid(valid_i[2]), .tx_data(data_i[7:0]),
    .tx_ready(ready_o[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut3 (
    .clk(clk), .reset_n(rst_n), .tx_valid(valid_i[3]), .tx_data(data_i[7:0]),
    .tx_ready(ready_o[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

  typedef struct {
    int          dut;
    logic [8:0]  data;
    int          nbits;
    logic [12:0] exp;   // frame bits, bit 0 = start bit
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d, ncyc, tx_bad, rdy_bad, busy_bad, done_bad;
    d = v.dut;
    ncyc = v.nbits * 10;
    tx_bad = 0; rdy_bad = 0; busy_bad = 0; done_bad = 0;
    @(negedge clk);
    data_i = v.data;
    valid_i[d] = 1'b1;
    @(posedge clk); #1;
    valid_i[d] = 1'b0;
    data_i = ~v.data;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (tx_o[d] !== v.exp[c / 10]) tx_bad++;
      if (ready_o[d] !== 1'b0) rdy_bad++;
      if (busy_o[d] !== 1'b1) busy_bad++;
      if (done_o[d] !== 1'b0) done_bad++;
      if (c % 10 == 5)
        check($sformatf("v%0d tx bit%0d", idx, c / 10), int'(tx_o[d]), int'(v.exp[c / 10]));
    end
    check($sformatf("v%0d tx bad cycles", idx), tx_bad, 0);
    check($sformatf("v%0d ready during frame", idx), rdy_bad, 0);
    check($sformatf("v%0d busy during frame", idx), busy_bad, 0);
    check($sformatf("v%0d early done", idx), done_bad, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d done at end", idx), int'(done_o[d]), 1);
    check($sformatf("v%0d busy at end", idx), int'(busy_o[d]), 0);
    check($sformatf("v%0d tx at end", idx), int'(tx_o[d]), 1);
    check($sformatf("v%0d ready at end", idx), int'(ready_o[d]), 1);
    @(posedge clk); #1;
    check($sformatf("v%0d done one cycle", idx), int'(done_o[d]), 0);
  endtask

  initial begin
    int done_cyc[$];
    int b2b_tx[int];
    int ndone, nlow, nbusy;
    for (int i = 0; i < 4; i++) valid_i[i] = 1'b0;

    vecs.push_back('{dut: 0, data: 9'h0A5, nbits: 10, exp: 13'b1101001010});
    vecs.push_back('{dut: 0, data: 9'h000, nbits: 10, exp: 13'b1000000000});
    vecs.push_back('{dut: 0, data: 9'h0FF, nbits: 10, exp: 13'b1111111110});
    vecs.push_back('{dut: 0, data: 9'h03C, nbits: 10, exp: 13'b1001111000});
`ifdef UART_TX_CFG_PARITY_EN
    vecs.push_back('{dut: 1, data: 9'h07F, nbits: 11, exp: 13'b11011111110});
    vecs.push_back('{dut: 1, data: 9'h02A, nbits: 11, exp: 13'b11001010100});
    vecs.push_back('{dut: 2, data: 9'h0A5, nbits: 11, exp: 13'b11101001010});
    vecs.push_back('{dut: 3, data: 9'h0A5, nbits: 11, exp: 13'b10101001010});
    vecs.push_back('{dut: 3, data: 9'h001, nbits: 11, exp: 13'b11000000010});
`else
    vecs.push_back('{dut: 1, data: 9'h07F, nbits: 10, exp: 13'b1111111110});
    vecs.push_back('{dut: 1, data: 9'h02A, nbits: 10, exp: 13'b1101010100});
    vecs.push_back('{dut: 2, data: 9'h0A5, nbits: 10, exp: 13'b1101001010});
    vecs.push_back('{dut: 3, data: 9'h0A5, nbits: 10, exp: 13'b1101001010});
    vecs.push_back('{dut: 3, data: 9'h001, nbits: 10, exp: 13'b1000000010});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst tx d%0d", i), int'(tx_o[i]), 1);
      check($sformatf("rst busy d%0d", i), int'(busy_o[i]), 0);
      check($sformatf("rst done d%0d", i), int'(done_o[i]), 0);
      check($sformatf("rst ready d%0d", i), int'(ready_o[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready after reset", int'(ready_o[0]), 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back: valid held high, 0x01 then 0x80
    @(negedge clk);
    data_i = 9'h001;
    valid_i[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 230; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == 1) data_i = 9'h080;
      if (c == 101) valid_i[0] = 1'b0;
      if (done_o[0] === 1'b1) done_cyc.push_back(c);
      if (c == 15 || c == 85 || c == 101 || c == 116 || c == 186) b2b_tx[c] = int'(tx_o[0]);
      if (c == 50) check("b2b ready mid frame", int'(ready_o[0]), 0);
      if (c == 100) check("b2b ready in gap", int'(ready_o[0]), 1);
      if (c == 210) begin
        check("b2b busy after", int'(busy_o[0]), 0);
        check("b2b ready after", int'(ready_o[0]), 1);
      end
    end
    check("b2b done count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      check("b2b done1 cycle", done_cyc[0], 100);
      check("b2b done2 cycle", done_cyc[1], 201);
    end
    check("b2b f1 bit0", b2b_tx[15], 1);
    check("b2b f1 bit7", b2b_tx[85], 0);
    check("b2b f2 start", b2b_tx[101], 0);
    check("b2b f2 bit0", b2b_tx[116], 0);
    check("b2b f2 bit7", b2b_tx[186], 1);

    // Reset at cycle 35 of a frame
    @(negedge clk);
    data_i = 9'h000;
    valid_i[0] = 1'b1;
    @(posedge clk); #1;
    valid_i[0] = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
    end
    check("abort tx before reset", int'(tx_o[0]), 0);
    rst_n = 1'b0;
    #1;
    check("ready gated by reset", int'(ready_o[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort tx", int'(tx_o[0]), 1);
    check("abort busy", int'(busy_o[0]), 0);
    check("abort ready", int'(ready_o[0]), 1);
    ndone = 0; nlow = 0; nbusy = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1) ndone++;
      if (tx_o[0] !== 1'b1) nlow++;
      if (busy_o[0] !== 1'b0) nbusy++;
    end
    check("abort no done", ndone, 0);
    check("abort no resend", nlow, 0);
    check("abort stays idle", nbusy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
